// File: rtl/redmule_pkg.sv
// redmule_pkg
// Shared types for the RedMulE tile scheduler.
//   tile_sched_state_e : job sequencing states
//   tile_sched_cntrl_t : {rst, first_load} bundle in the same layout as the
//                        memory scheduler's scheduler-control input
//   TileSchedWdW       : width of the optional idle watchdog
//                        (used when REDMULE_TILE_SCHED_WATCHDOG_EN is defined)
package redmule_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    LOAD   = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4
  } tile_sched_state_e;

  typedef struct packed {
    logic rst;
    logic first_load;
  } tile_sched_cntrl_t;

  localparam int unsigned TileSchedWdW = 20;

endpackage

// File: rtl/redmule_tile_scheduler_sat_counter.sv
// redmule_sat_counter
// CntW-wide up counter that saturates at a runtime limit.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear         : synchronous clear to zero (wins over en)
//   en            : count request
//   limit         : value at which the counter holds
//   count         : registered count
//   count_nxt     : value the counter takes at the next edge
//   ovf           : en asserted while count == limit (request dropped)
module redmule_sat_counter #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear,
  input  logic            en,
  input  logic [CntW-1:0] limit,
  output logic [CntW-1:0] count,
  output logic [CntW-1:0] count_nxt,
  output logic            ovf
);

  logic [CntW-1:0] cnt_q;

  always_comb begin
    ovf       = en && (cnt_q == limit);
    count_nxt = cnt_q;
    if (clear) begin
      count_nxt = '0;
    end else if (en && !ovf) begin
      count_nxt = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= count_nxt;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/redmule_tile_scheduler.sv
// redmule_tile_scheduler
// Sequences one GEMM job: pulses the streamer reset, holds first_load until
// the X source accepts it, counts X loads and Z stores until both totals are
// reached, then pulses done.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   clear_i                : synchronous soft clear (highest priority)
//   start_i                : job start, totals valid this cycle
//   tot_x_read_i/tot_z_store_i : job totals
//   x_ready_start_i        : X source accepts first load
//   x_done_i, z_done_i     : X load / Z store completion pulses
//   z_issue_i              : engine has a Z tile ready to store
//   rst_o, first_load_o    : memory scheduler control
//   z_priority_o           : Z store priority (registered)
//   busy_o, done_o, err_o  : job status
//   x_cnt_o, z_cnt_o       : completed loads / stores
// Optional: define REDMULE_TILE_SCHED_WATCHDOG_EN to enable the idle watchdog
// in LOAD/RUN that sets err_o and forces FINISH after 2^20-1 quiet cycles.
module redmule_tile_scheduler
  import redmule_pkg::*;
#(
  parameter int unsigned CntW     = 16,
  parameter int unsigned ZPrioThr = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            start_i,
  input  logic [CntW-1:0] tot_x_read_i,
  input  logic [CntW-1:0] tot_z_store_i,
  input  logic            x_ready_start_i,
  input  logic            x_done_i,
  input  logic            z_issue_i,
  input  logic            z_done_i,
  output logic            rst_o,
  output logic            first_load_o,
  output logic            z_priority_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [CntW-1:0] x_cnt_o,
  output logic [CntW-1:0] z_cnt_o
);

  tile_sched_state_e state_q, state_d;
  tile_sched_cntrl_t cntrl;

  logic [CntW-1:0] tot_x_q, tot_z_q;
  logic [CntW-1:0] x_cnt, z_cnt, iss_cnt;
  logic [CntW-1:0] x_nxt, z_nxt, iss_nxt;
  logic [CntW-1:0] pending, pending_nxt;
  logic            x_ovf, z_ovf, iss_ovf;
  logic            in_run, accept_start, cnt_clear;
  logic            z_underflow, err_set;
  logic            err_q, zprio_q;
  logic            wd_fire;

  assign in_run       = (state_q == RUN);
  assign accept_start = (state_q == IDLE) && start_i;
  // Counts stay visible after a job and are wiped only when the next job
  // begins, in RST, or on a soft clear.
  assign cnt_clear    = clear_i || accept_start || (state_q == RST);
  assign pending      = iss_cnt - z_cnt;
  assign pending_nxt  = iss_nxt - z_nxt;
  assign z_underflow  = in_run && z_done_i && (pending == '0);

  redmule_sat_counter #(.CntW(CntW)) u_x_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (cnt_clear),
    .en        (in_run && x_done_i),
    .limit     (tot_x_q),
    .count     (x_cnt),
    .count_nxt (x_nxt),
    .ovf       (x_ovf)
  );

  // A store completion with nothing outstanding is dropped, not counted.
  redmule_sat_counter #(.CntW(CntW)) u_z_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (cnt_clear),
    .en        (in_run && z_done_i && (pending != '0)),
    .limit     (tot_z_q),
    .count     (z_cnt),
    .count_nxt (z_nxt),
    .ovf       (z_ovf)
  );

  // Issued count only bounds pending; hitting all-ones would corrupt the
  // pending difference, so that case is reported as an error.
  redmule_sat_counter #(.CntW(CntW)) u_iss_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (cnt_clear),
    .en        (in_run && z_issue_i),
    .limit     ({CntW{1'b1}}),
    .count     (iss_cnt),
    .count_nxt (iss_nxt),
    .ovf       (iss_ovf)
  );

`ifdef REDMULE_TILE_SCHED_WATCHDOG_EN
  logic [TileSchedWdW-1:0] wd_q;
  logic                    wd_active;

  assign wd_active = (state_q == LOAD) || (state_q == RUN);
  assign wd_fire   = wd_active && (wd_q == {TileSchedWdW{1'b1}});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if (clear_i || !wd_active || x_done_i || z_done_i || x_ready_start_i) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign err_set = ((x_done_i || z_done_i) && !in_run) || x_ovf || z_ovf ||
                   iss_ovf || z_underflow || wd_fire;

  // Completion is judged on the post-update counts so done follows the last
  // completion pulse by exactly one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ((tot_x_read_i == '0) || (tot_z_store_i == '0)) ? FINISH : RST;
        end
      end
      RST:    state_d = LOAD;
      LOAD:   if (x_ready_start_i) state_d = RUN;
      RUN:    if ((x_nxt == tot_x_q) && (z_nxt == tot_z_q)) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wd_fire) state_d = FINISH;
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tot_x_q <= '0;
      tot_z_q <= '0;
      err_q   <= 1'b0;
      zprio_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_start && !clear_i) begin
        tot_x_q <= tot_x_read_i;
        tot_z_q <= tot_z_store_i;
      end
      err_q   <= clear_i ? 1'b0 : (err_q | err_set);
      zprio_q <= !clear_i && in_run && (pending_nxt >= CntW'(ZPrioThr));
    end
  end

  assign cntrl.rst        = (state_q == RST);
  assign cntrl.first_load = (state_q == LOAD);

  assign rst_o        = cntrl.rst;
  assign first_load_o = cntrl.first_load;
  assign z_priority_o = zprio_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == FINISH);
  assign err_o        = err_q;
  assign x_cnt_o      = x_cnt;
  assign z_cnt_o      = z_cnt;

endmodule

// File: tb/tb_redmule_tile_scheduler.sv
// tb_redmule_tile_scheduler
// Directed scoreboard bench: stimulus pushes expected done/rst/first_load
// events and cycle-stamped output values; a negedge monitor pops and compares.
module tb_redmule_tile_scheduler;

  localparam int CntW = 16;

  typedef enum int {SIG_RST, SIG_FL, SIG_PRIO, SIG_BUSY, SIG_DONE, SIG_ERR, SIG_XCNT, SIG_ZCNT} sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [15:0] val;
    string       name;
  } timed_exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] x;
    logic [15:0] z;
    logic        err;
  } done_exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear, start, x_ready_start, x_done, z_issue, z_done;
  logic [CntW-1:0] tot_x, tot_z;
  logic            rst_out, first_load, z_priority, busy, done, err;
  logic [CntW-1:0] x_cnt, z_cnt;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit stim_done = 1'b0;

  timed_exp_t tq[$];
  done_exp_t  done_q[$];
  int         rst_q[$];
  int         fl_q[$];

  done_exp_t   de;
  int          ec;
  logic [15:0] got;

  redmule_tile_scheduler #(.CntW(CntW), .ZPrioThr(2)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .start_i         (start),
    .tot_x_read_i    (tot_x),
    .tot_z_store_i   (tot_z),
    .x_ready_start_i (x_ready_start),
    .x_done_i        (x_done),
    .z_issue_i       (z_issue),
    .z_done_i        (z_done),
    .rst_o           (rst_out),
    .first_load_o    (first_load),
    .z_priority_o    (z_priority),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .x_cnt_o         (x_cnt),
    .z_cnt_o         (z_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sig_val(sig_e s);
    case (s)
      SIG_RST:  return {15'd0, rst_out};
      SIG_FL:   return {15'd0, first_load};
      SIG_PRIO: return {15'd0, z_priority};
      SIG_BUSY: return {15'd0, busy};
      SIG_DONE: return {15'd0, done};
      SIG_ERR:  return {15'd0, err};
      SIG_XCNT: return x_cnt;
      default:  return z_cnt;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input sig_e s, input logic [15:0] v, input string n);
    timed_exp_t t;
    t.cyc = c; t.sig = s; t.val = v; t.name = n;
    tq.push_back(t);
  endtask

  task automatic expect_done(input int c, input logic [15:0] x, input logic [15:0] z, input logic e);
    done_exp_t d;
    d.cyc = c; d.x = x; d.z = z; d.err = e;
    done_q.push_back(d);
  endtask

  task automatic idle_inputs();
    clear = 0; start = 0; x_ready_start = 0; x_done = 0; z_issue = 0; z_done = 0;
  endtask

  // Monitor: compares every DUT event and every cycle-stamped expectation.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL done_unexpected: got done at cycle %0d, none expected", cyc);
      end else begin
        de = done_q.pop_front();
        if (de.cyc != cyc || x_cnt != de.x || z_cnt != de.z || err != de.err) begin
          errors++;
          $display("[TB] FAIL done_event: got cyc=%0d x=%0d z=%0d err=%0b, expected cyc=%0d x=%0d z=%0d err=%0b",
                   cyc, x_cnt, z_cnt, err, de.cyc, de.x, de.z, de.err);
        end
      end
    end
    if (rst_out) begin
      checks++;
      if (rst_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL rst_unexpected: rst_o at cycle %0d, none expected", cyc);
      end else begin
        ec = rst_q.pop_front();
        if (ec != cyc) begin
          errors++;
          $display("[TB] FAIL rst_pulse: got cycle %0d, expected cycle %0d", cyc, ec);
        end
      end
    end
    if (first_load) begin
      checks++;
      if (fl_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL first_load_unexpected: first_load_o at cycle %0d, none expected", cyc);
      end else begin
        ec = fl_q.pop_front();
        if (ec != cyc) begin
          errors++;
          $display("[TB] FAIL first_load_cycle: got cycle %0d, expected cycle %0d", cyc, ec);
        end
      end
    end
    for (int i = tq.size() - 1; i >= 0; i--) begin
      if (tq[i].cyc == cyc) begin
        checks++;
        got = sig_val(tq[i].sig);
        if (got !== tq[i].val) begin
          errors++;
          $display("[TB] FAIL %s: cycle %0d got %0d, expected %0d", tq[i].name, cyc, got, tq[i].val);
        end
        tq.delete(i);
      end
    end
    if (stim_done) begin
      checks++;
      if (tq.size() != 0 || done_q.size() != 0 || rst_q.size() != 0 || fl_q.size() != 0) begin
        errors++;
        $display("[TB] FAIL missing_events: got leftovers timed=%0d done=%0d rst=%0d fl=%0d, expected all 0",
                 tq.size(), done_q.size(), rst_q.size(), fl_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int s;
    rst_n = 0; tot_x = '0; tot_z = '0;
    idle_inputs();
    tick();
    // Reset values
    expect_at(cyc, SIG_RST, 0, "reset_rst");
    expect_at(cyc, SIG_FL, 0, "reset_first_load");
    expect_at(cyc, SIG_PRIO, 0, "reset_prio");
    expect_at(cyc, SIG_BUSY, 0, "reset_busy");
    expect_at(cyc, SIG_DONE, 0, "reset_done");
    expect_at(cyc, SIG_ERR, 0, "reset_err");
    expect_at(cyc, SIG_XCNT, 0, "reset_xcnt");
    expect_at(cyc, SIG_ZCNT, 0, "reset_zcnt");
    tick();
    rst_n = 1;
    tick();

    // Job 1: tot_x=4, tot_z=2, x_ready_start in LOAD's second cycle
    s = cyc;
    start = 1; tot_x = 4; tot_z = 2;
    rst_q.push_back(s + 1);
    fl_q.push_back(s + 2); fl_q.push_back(s + 3);
    expect_at(s + 6, SIG_XCNT, 2, "job1_xcnt_mid");
    expect_done(s + 8, 4, 2, 1'b0);
    expect_at(s + 8, SIG_BUSY, 1, "job1_busy_at_done");
    expect_at(s + 9, SIG_BUSY, 0, "job1_busy_after");
    expect_at(s + 9, SIG_ERR, 0, "job1_err");
    expect_at(s + 9, SIG_XCNT, 4, "job1_xcnt_kept");
    tick(); start = 0;
    tick();
    tick(); x_ready_start = 1;
    tick(); x_ready_start = 0; x_done = 1; z_issue = 1;
    tick(); start = 1; tot_x = 7;          // start while busy: ignored
    tick(); start = 0; z_issue = 0; z_done = 1;
    tick();
    tick(); idle_inputs();
    tick(); tick();

    // Job 2: zero X total finishes immediately with no rst/first_load
    s = cyc;
    start = 1; tot_x = 0; tot_z = 5;
    expect_done(s + 1, 0, 0, 1'b0);
    expect_at(s + 2, SIG_BUSY, 0, "job2_busy_after");
    tick(); start = 0;
    tick(); tick();

    // Job 3: Z priority threshold
    s = cyc;
    start = 1; tot_x = 1; tot_z = 3;
    rst_q.push_back(s + 1);
    fl_q.push_back(s + 2);
    expect_at(s + 4, SIG_PRIO, 0, "prio_after_1st_issue");
    expect_at(s + 5, SIG_PRIO, 1, "prio_after_2nd_issue");
    expect_at(s + 7, SIG_PRIO, 1, "prio_pending3");
    expect_at(s + 8, SIG_PRIO, 1, "prio_pending2");
    expect_at(s + 9, SIG_PRIO, 0, "prio_pending1");
    expect_done(s + 10, 1, 3, 1'b0);
    expect_at(s + 11, SIG_ERR, 0, "job3_err");
    tick(); start = 0;
    tick(); x_ready_start = 1;
    tick(); x_ready_start = 0; z_issue = 1;
    tick();
    tick();
    tick(); z_issue = 0;
    tick(); z_done = 1;
    tick();
    tick(); x_done = 1;
    tick(); idle_inputs();
    tick(); tick();

    // Job 4: X overflow and out-of-RUN completion set sticky error
    s = cyc;
    start = 1; tot_x = 2; tot_z = 1;
    rst_q.push_back(s + 1);
    fl_q.push_back(s + 2);
    expect_at(s + 5, SIG_ERR, 0, "err_before_overflow");
    expect_at(s + 6, SIG_ERR, 1, "err_x_overflow");
    expect_at(s + 6, SIG_XCNT, 2, "xcnt_saturated");
    expect_done(s + 8, 2, 1, 1'b1);
    expect_at(s + 10, SIG_ERR, 1, "err_sticky");
    expect_at(s + 11, SIG_ERR, 0, "err_cleared");
    expect_at(s + 11, SIG_XCNT, 0, "xcnt_cleared");
    expect_at(s + 13, SIG_ERR, 1, "err_xdone_idle");
    expect_at(s + 14, SIG_ERR, 0, "err_cleared2");
    tick(); start = 0;
    tick(); x_ready_start = 1;
    tick(); x_ready_start = 0; x_done = 1;
    tick();
    tick();
    tick(); x_done = 0; z_issue = 1;
    tick(); z_issue = 0; z_done = 1;
    tick(); z_done = 0;
    tick();
    tick(); clear = 1;
    tick(); clear = 0;
    tick(); x_done = 1;
    tick(); x_done = 0; clear = 1;
    tick(); clear = 0;
    tick();

    // Job 5: clear mid-RUN, then a fresh job
    s = cyc;
    start = 1; tot_x = 3; tot_z = 1;
    rst_q.push_back(s + 1);
    fl_q.push_back(s + 2);
    expect_at(s + 4, SIG_XCNT, 1, "clear_xcnt_before");
    expect_at(s + 5, SIG_BUSY, 0, "clear_busy");
    expect_at(s + 5, SIG_XCNT, 0, "clear_xcnt_after");
    expect_at(s + 5, SIG_ERR, 0, "clear_err");
    rst_q.push_back(s + 7);
    fl_q.push_back(s + 8);
    expect_done(s + 11, 1, 1, 1'b0);
    tick(); start = 0;
    tick(); x_ready_start = 1;
    tick(); x_ready_start = 0; x_done = 1;
    tick(); x_done = 0; clear = 1;
    tick(); clear = 0;
    tick(); start = 1; tot_x = 1; tot_z = 1;
    tick(); start = 0;
    tick(); x_ready_start = 1;
    tick(); x_ready_start = 0; x_done = 1; z_issue = 1;
    tick(); x_done = 0; z_issue = 0; z_done = 1;
    tick(); idle_inputs();
    tick(); tick();

    // Job 6: LOAD waits indefinitely without x_ready_start
    s = cyc;
    start = 1; tot_x = 1; tot_z = 1;
    rst_q.push_back(s + 1);
    for (int c = s + 2; c <= s + 200; c++) fl_q.push_back(c);
    expect_at(s + 200, SIG_BUSY, 1, "load_wait_busy");
    expect_at(s + 201, SIG_BUSY, 0, "load_wait_cleared");
    tick(); start = 0;
    while (cyc < s + 200) tick();
    clear = 1;
    tick(); clear = 0;
    tick(); tick();
    stim_done = 1'b1;
  end

endmodule
